sprite_scan_controller: RTL and testbench

SPRITE_SCAN_CONTROLLER -- requirements
Module: sprite_scan_controller

---
 rtl/sprite_scan_controller_if.sv | 37 +++
 rtl/sprite_scan_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_sprite_scan_controller.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_scan_controller_if.sv
// Sprite scan controller bus bundle.
// Groups the per-line control, register-bank read port, address-generator
// handshake, line-buffer write port and status flags.
//   master : the scan controller (drives reg_rd_addr, sprite_*, pixel_*,
//            lb_wr_*, busy, done, overrun, timeout_err)
//   slave  : the surrounding video pipeline (drives line_start, line_y,
//            reg_rd_data, counter_finished)
`timescale 1ns/1ps
interface sprite_scan_controller_if;
  logic        line_start;
  logic [9:0]  line_y;
  logic [4:0]  reg_rd_addr;
  logic [31:0] reg_rd_data;
  logic [31:0] sprite_datas;
  logic        sprite_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        counter_finished;
  logic        lb_wr_en;
  logic [9:0]  lb_wr_x;
  logic        busy;
  logic        done;
  logic        overrun;
  logic        timeout_err;

  modport master (
    input  line_start, line_y, reg_rd_data, counter_finished,
    output reg_rd_addr, sprite_datas, sprite_on, pixel_x, pixel_y,
           lb_wr_en, lb_wr_x, busy, done, overrun, timeout_err
  );

  modport slave (
    output line_start, line_y, reg_rd_data, counter_finished,
    input  reg_rd_addr, sprite_datas, sprite_on, pixel_x, pixel_y,
           lb_wr_en, lb_wr_x, busy, done, overrun, timeout_err
  );
endinterface

// File: rtl/sprite_scan_controller.sv
// Sprite scan controller.
// For each line_start it walks every sprite register slot, checks whether the
// sprite covers the requested line, and for each hit drives the address
// generator (sprite_on/pixel_x) until it reports completion. A delay line
// realigns sprite_on/pixel_x with sprite-memory data to form line-buffer
// writes.
// Ports:
//   i_clk_pixel : pixel clock
//   i_reset     : asynchronous active-high reset
//   io_scan     : controller side (master) of sprite_scan_controller_if
//
// State table
//   state  | meaning
//   IDLE   | waiting for line_start
//   READ   | reg_rd_addr = slot, bank read in flight
//   CHECK  | slot word valid; capture it and test for a hit on the line
//   DRAW   | sprite_on high, pixel_x stepping, wait counter_finished/timeout
//   DRAIN  | let MEM_LATENCY cycles of memory data reach the line buffer
//   NEXT   | advance slot or finish
//   DONE   | one-cycle done pulse
`timescale 1ns/1ps
module sprite_scan_controller #(
  parameter int NUM_SPRITES = 32,
  parameter int SPRITE_SIZE = 20,
  parameter int MEM_LATENCY = 2,
  parameter int H_ACTIVE    = 640
) (
  input  logic                      i_clk_pixel,
  input  logic                      i_reset,
  sprite_scan_controller_if.master  io_scan
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CHECK, S_DRAW, S_DRAIN, S_NEXT, S_DONE
  } state_t;

  localparam logic [4:0] LP_LAST_SLOT   = 5'(NUM_SPRITES - 1);
  localparam logic [4:0] LP_DRAW_TC     = 5'd31;
  localparam logic [4:0] LP_DRAIN_TC    = 5'(MEM_LATENCY - 1);

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_slot;
  logic [9:0]  r_line_y;
  logic [31:0] r_sprite_datas;
  logic [9:0]  r_pixel_x;
  logic [4:0]  r_timer;
  logic        r_overrun;
  logic        r_timeout_err;
  logic        r_pipe_en [MEM_LATENCY];
  logic [9:0]  r_pipe_x  [MEM_LATENCY];

  logic        w_abort;
  logic        w_load_line;
  logic        w_slot_clr;
  logic        w_slot_inc;
  logic        w_capture;
  logic        w_load_x;
  logic        w_inc_x;
  logic        w_tmr_draw;
  logic        w_tmr_drain;
  logic        w_tmr_dec;
  logic        w_set_timeout;
  logic        w_sprite_on;

  // Hit test in 11 bits so y + SPRITE_SIZE never wraps past line 1023.
  logic        w_spr_en;
  logic [9:0]  w_spr_x;
  logic [10:0] w_y_lo;
  logic [10:0] w_y_hi;
  logic [10:0] w_line;
  logic        w_hit;

  assign w_spr_en = io_scan.reg_rd_data[29];
  assign w_spr_x  = io_scan.reg_rd_data[28:19];
  assign w_y_lo   = {1'b0, io_scan.reg_rd_data[18:9]};
  assign w_y_hi   = w_y_lo + 11'(SPRITE_SIZE);
  assign w_line   = {1'b0, r_line_y};
  assign w_hit    = w_spr_en && (w_line >= w_y_lo) && (w_line < w_y_hi);

  // A new line request while busy abandons the current pass.
  assign w_abort     = io_scan.line_start && (r_state != S_IDLE);
  assign w_sprite_on = (r_state == S_DRAW);

  always_ff @(posedge i_clk_pixel or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_load_line   = 1'b0;
    w_slot_clr    = 1'b0;
    w_slot_inc    = 1'b0;
    w_capture     = 1'b0;
    w_load_x      = 1'b0;
    w_inc_x       = 1'b0;
    w_tmr_draw    = 1'b0;
    w_tmr_drain   = 1'b0;
    w_tmr_dec     = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_scan.line_start) begin
          w_next      = S_READ;
          w_load_line = 1'b1;
          w_slot_clr  = 1'b1;
        end
      end
      S_READ:  w_next = S_CHECK;
      S_CHECK: begin
        w_capture = 1'b1;
        if (w_hit) begin
          w_next     = S_DRAW;
          w_load_x   = 1'b1;
          w_tmr_draw = 1'b1;
        end else begin
          w_next = S_NEXT;
        end
      end
      S_DRAW: begin
        w_inc_x = 1'b1;
        if (io_scan.counter_finished) begin
          w_next      = S_DRAIN;
          w_tmr_drain = 1'b1;
        end else if (r_timer == '0) begin
          w_next        = S_DRAIN;
          w_tmr_drain   = 1'b1;
          w_set_timeout = 1'b1;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_timer == '0) w_next = S_NEXT;
        else               w_tmr_dec = 1'b1;
      end
      S_NEXT: begin
        if (r_slot == LP_LAST_SLOT) begin
          w_next = S_DONE;
        end else begin
          w_next     = S_READ;
          w_slot_inc = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_abort) begin
      w_next        = S_READ;
      w_load_line   = 1'b1;
      w_slot_clr    = 1'b1;
      w_slot_inc    = 1'b0;
      w_capture     = 1'b0;
      w_load_x      = 1'b0;
      w_inc_x       = 1'b0;
      w_tmr_draw    = 1'b0;
      w_tmr_drain   = 1'b0;
      w_tmr_dec     = 1'b0;
      w_set_timeout = 1'b0;
    end
  end

  always_ff @(posedge i_clk_pixel or posedge i_reset) begin
    if (i_reset) begin
      r_slot         <= '0;
      r_line_y       <= '0;
      r_sprite_datas <= '0;
      r_pixel_x      <= '0;
      r_timer        <= '0;
      r_overrun      <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      if (w_load_line) r_line_y <= io_scan.line_y;
      if (w_slot_clr)      r_slot <= '0;
      else if (w_slot_inc) r_slot <= r_slot + 5'd1;
      if (w_capture) r_sprite_datas <= io_scan.reg_rd_data;
      if (w_load_x)     r_pixel_x <= w_spr_x;
      else if (w_inc_x) r_pixel_x <= r_pixel_x + 10'd1;
      // Single down-counter shared by the DRAW timeout and DRAIN hold.
      if (w_tmr_draw)       r_timer <= LP_DRAW_TC;
      else if (w_tmr_drain) r_timer <= LP_DRAIN_TC;
      else if (w_tmr_dec)   r_timer <= r_timer - 5'd1;
      r_overrun <= w_abort;
      if (w_set_timeout) r_timeout_err <= 1'b1;
    end
  end

  // Delay line matching sprite-memory latency; flushed on abort so writes
  // from the abandoned sprite never reach the line buffer.
  always_ff @(posedge i_clk_pixel or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        r_pipe_en[i] <= 1'b0;
        r_pipe_x[i]  <= '0;
      end
    end else begin
      r_pipe_en[0] <= w_sprite_on && !w_abort;
      r_pipe_x[0]  <= r_pixel_x;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        r_pipe_en[i] <= r_pipe_en[i-1] && !w_abort;
        r_pipe_x[i]  <= r_pipe_x[i-1];
      end
    end
  end

  assign io_scan.reg_rd_addr  = r_slot;
  assign io_scan.sprite_datas = r_sprite_datas;
  assign io_scan.sprite_on    = w_sprite_on;
  assign io_scan.pixel_x      = r_pixel_x;
  assign io_scan.pixel_y      = r_line_y;
  assign io_scan.lb_wr_x      = r_pipe_x[MEM_LATENCY-1];
  assign io_scan.lb_wr_en     = r_pipe_en[MEM_LATENCY-1] &&
                                ({1'b0, r_pipe_x[MEM_LATENCY-1]} < 11'(H_ACTIVE));
  assign io_scan.busy         = (r_state != S_IDLE);
  assign io_scan.done         = (r_state == S_DONE);
  assign io_scan.overrun      = r_overrun;
  assign io_scan.timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_sprite_scan_controller.sv
// Directed bench for sprite_scan_controller: register bank and address
// generator models surround the DUT; each task drives a scenario and checks
// hand-computed results.
`timescale 1ns/1ps
module tb_sprite_scan_controller;
  localparam int NUM_SPRITES = 32;
  localparam int SPRITE_SIZE = 20;
  localparam int MEM_LATENCY = 2;
  localparam int H_ACTIVE    = 640;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] bank [32];
  logic        cf_en = 1'b1;
  int          gen_cnt = 0;

  // scan results
  int          s_done_cyc, s_done_cnt, s_son, s_wr, s_first_son, s_first_wr;
  int          s_seq_err, s_ovr;
  logic [9:0]  s_first_x, s_last_x;
  logic [31:0] s_dat_at_son;

  sprite_scan_controller_if bus ();

  sprite_scan_controller #(
    .NUM_SPRITES (NUM_SPRITES),
    .SPRITE_SIZE (SPRITE_SIZE),
    .MEM_LATENCY (MEM_LATENCY),
    .H_ACTIVE    (H_ACTIVE)
  ) dut (
    .i_clk_pixel (clk),
    .i_reset     (rst),
    .io_scan     (bus)
  );

  always #5 clk = ~clk;

  // Register bank: one-cycle synchronous read.
  always @(posedge clk) bus.reg_rd_data <= bank[bus.reg_rd_addr];

  // Address generator: reports completion on its SPRITE_SIZE-th address.
  always @(posedge clk) begin
    if (!bus.sprite_on) gen_cnt <= 0;
    else                gen_cnt <= gen_cnt + 1;
  end
  assign bus.counter_finished = cf_en && bus.sprite_on && (gen_cnt == SPRITE_SIZE - 1);

  function automatic logic [31:0] word(input logic en, input logic [9:0] x,
                                       input logic [9:0] y, input logic [8:0] off);
    return {2'b00, en, x, y, off};
  endfunction

  task automatic clear_bank();
    for (int i = 0; i < 32; i++) bank[i] = 32'h0;
  endtask

  task automatic pulse_line(input logic [9:0] ly);
    @(posedge clk); #1;
    bus.line_y     = ly;
    bus.line_start = 1'b1;
    @(posedge clk); #1;
    bus.line_start = 1'b0;
  endtask

  // Pulses line_start and observes one full pass; cycle 1 is the cycle after
  // line_start is sampled.
  task automatic run_scan(input logic [9:0] ly);
    int cyc;
    logic prev_en;
    logic [9:0] prev_x;
    s_done_cyc = -1; s_done_cnt = 0; s_son = 0; s_wr = 0;
    s_first_son = -1; s_first_wr = -1; s_seq_err = 0; s_ovr = 0;
    s_first_x = '0; s_last_x = '0; s_dat_at_son = '0;
    prev_en = 1'b0; prev_x = '0;
    pulse_line(ly);
    cyc = 1;
    while (cyc < 2000) begin
      @(negedge clk);
      if (bus.sprite_on) begin
        if (s_first_son < 0) begin
          s_first_son  = cyc;
          s_dat_at_son = bus.sprite_datas;
        end
        s_son++;
      end
      if (bus.lb_wr_en) begin
        if (s_first_wr < 0) begin
          s_first_wr = cyc;
          s_first_x  = bus.lb_wr_x;
        end
        if (prev_en && (bus.lb_wr_x != prev_x + 10'd1)) s_seq_err++;
        s_last_x = bus.lb_wr_x;
        s_wr++;
      end
      prev_en = bus.lb_wr_en;
      prev_x  = bus.lb_wr_x;
      if (bus.overrun) s_ovr++;
      if (bus.done) begin
        s_done_cnt++;
        if (s_done_cyc < 0) s_done_cyc = cyc;
      end
      if (s_done_cyc >= 0 && cyc >= s_done_cyc + 4) break;
      cyc++;
    end
  endtask

  task automatic test_reset();
    bus.line_start = 1'b0;
    bus.line_y     = '0;
    clear_bank();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.sprite_on, bus.done, bus.overrun, bus.timeout_err, bus.lb_wr_en} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000000",
               {bus.busy, bus.sprite_on, bus.done, bus.overrun, bus.timeout_err, bus.lb_wr_en});
    end
    n_checks++;
    if ({bus.pixel_x, bus.pixel_y, bus.lb_wr_x, bus.reg_rd_addr} !== 35'b0) begin
      n_fail++;
      $display("FAIL reset_data: got px=%0d py=%0d lbx=%0d addr=%0d expected all 0",
               bus.pixel_x, bus.pixel_y, bus.lb_wr_x, bus.reg_rd_addr);
    end
    n_checks++;
    if (bus.sprite_datas !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_sprite_datas: got %h expected 00000000", bus.sprite_datas);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_single_hit();
    clear_bank();
    bank[0] = word(1'b1, 10'd100, 10'd50, 9'd3);
    run_scan(10'd55);
    n_checks++;
    if (s_done_cyc !== 119) begin n_fail++; $display("FAIL single_done_cycle: got %0d expected 119", s_done_cyc); end
    n_checks++;
    if (s_done_cnt !== 1) begin n_fail++; $display("FAIL single_done_pulses: got %0d expected 1", s_done_cnt); end
    n_checks++;
    if (s_son !== 20) begin n_fail++; $display("FAIL single_sprite_on_cycles: got %0d expected 20", s_son); end
    n_checks++;
    if (s_first_son !== 3) begin n_fail++; $display("FAIL single_draw_start: got %0d expected 3", s_first_son); end
    n_checks++;
    if (s_first_wr - s_first_son !== 2) begin
      n_fail++; $display("FAIL single_wr_lag: got %0d expected 2", s_first_wr - s_first_son);
    end
    n_checks++;
    if (s_wr !== 20 || s_first_x !== 10'd100 || s_last_x !== 10'd119 || s_seq_err !== 0) begin
      n_fail++;
      $display("FAIL single_lb_writes: got n=%0d first=%0d last=%0d seqerr=%0d expected 20/100/119/0",
               s_wr, s_first_x, s_last_x, s_seq_err);
    end
    n_checks++;
    if (s_dat_at_son !== word(1'b1, 10'd100, 10'd50, 9'd3)) begin
      n_fail++; $display("FAIL single_sprite_datas: got %h expected %h", s_dat_at_son, word(1'b1, 10'd100, 10'd50, 9'd3));
    end
    n_checks++;
    if (bus.pixel_y !== 10'd55) begin n_fail++; $display("FAIL single_pixel_y: got %0d expected 55", bus.pixel_y); end
    n_checks++;
    if ({s_ovr != 0, bus.timeout_err, bus.busy} !== 3'b000) begin
      n_fail++; $display("FAIL single_status: got ovr=%0d tmo=%b busy=%b expected 0/0/0", s_ovr, bus.timeout_err, bus.busy);
    end
  endtask

  task automatic test_boundary();
    logic [9:0] lines [4];
    int exp_son [4];
    int exp_done [4];
    lines = '{10'd69, 10'd70, 10'd49, 10'd50};
    exp_son = '{20, 0, 0, 20};
    exp_done = '{119, 97, 97, 119};
    clear_bank();
    bank[0] = word(1'b1, 10'd100, 10'd50, 9'd0);
    for (int i = 0; i < 4; i++) begin
      run_scan(lines[i]);
      n_checks++;
      if (s_son !== exp_son[i] || s_done_cyc !== exp_done[i]) begin
        n_fail++;
        $display("FAIL boundary_line_%0d: got son=%0d done=%0d expected son=%0d done=%0d",
                 lines[i], s_son, s_done_cyc, exp_son[i], exp_done[i]);
      end
    end
  endtask

  task automatic test_right_edge();
    clear_bank();
    bank[0] = word(1'b1, 10'd630, 10'd50, 9'd0);
    run_scan(10'd55);
    n_checks++;
    if (s_son !== 20) begin n_fail++; $display("FAIL edge_sprite_on_cycles: got %0d expected 20", s_son); end
    n_checks++;
    if (s_wr !== 10 || s_first_x !== 10'd630 || s_last_x !== 10'd639) begin
      n_fail++;
      $display("FAIL edge_lb_writes: got n=%0d first=%0d last=%0d expected 10/630/639", s_wr, s_first_x, s_last_x);
    end
  endtask

  task automatic test_all_disabled();
    clear_bank();
    run_scan(10'd200);
    n_checks++;
    if (s_done_cyc !== 97) begin n_fail++; $display("FAIL disabled_done_cycle: got %0d expected 97", s_done_cyc); end
    n_checks++;
    if (s_son !== 0 || s_wr !== 0 || s_done_cnt !== 1) begin
      n_fail++; $display("FAIL disabled_activity: got son=%0d wr=%0d done=%0d expected 0/0/1", s_son, s_wr, s_done_cnt);
    end
  endtask

  task automatic test_multi_hit();
    clear_bank();
    bank[0]  = word(1'b1, 10'd10, 10'd0, 9'd0);
    bank[31] = word(1'b1, 10'd1015, 10'd0, 9'd0);
    run_scan(10'd0);
    n_checks++;
    if (s_done_cyc !== 141) begin n_fail++; $display("FAIL multi_done_cycle: got %0d expected 141", s_done_cyc); end
    n_checks++;
    if (s_son !== 40) begin n_fail++; $display("FAIL multi_sprite_on_cycles: got %0d expected 40", s_son); end
    n_checks++;
    if (s_wr !== 31 || s_first_x !== 10'd10 || s_last_x !== 10'd10 || s_seq_err !== 0) begin
      n_fail++;
      $display("FAIL multi_lb_writes: got n=%0d first=%0d last=%0d seqerr=%0d expected 31/10/10/0",
               s_wr, s_first_x, s_last_x, s_seq_err);
    end
  endtask

  task automatic test_abort();
    int n, son, wr, ovr, cyc, done_cyc;
    clear_bank();
    bank[2] = word(1'b1, 10'd100, 10'd50, 9'd0);
    pulse_line(10'd55);
    n = 0;
    for (int k = 0; k < 200 && n < 6; k++) begin
      @(negedge clk);
      if (bus.sprite_on) n++;
    end
    n_checks++;
    if (n !== 6) begin n_fail++; $display("FAIL abort_reach_draw: got %0d draw cycles expected 6", n); end
    pulse_line(10'd300);
    n_checks++;
    if (bus.sprite_on !== 1'b0 || bus.overrun !== 1'b1) begin
      n_fail++; $display("FAIL abort_edge: got son=%b ovr=%b expected 0/1", bus.sprite_on, bus.overrun);
    end
    n_checks++;
    if (bus.reg_rd_addr !== 5'd0 || bus.pixel_y !== 10'd300 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_restart: got addr=%0d py=%0d busy=%b expected 0/300/1", bus.reg_rd_addr, bus.pixel_y, bus.busy);
    end
    son = 0; wr = 0; ovr = 0; done_cyc = -1;
    cyc = 1;
    while (cyc < 400) begin
      @(negedge clk);
      if (bus.sprite_on) son++;
      if (bus.lb_wr_en)  wr++;
      if (bus.overrun)   ovr++;
      if (bus.done) begin done_cyc = cyc; break; end
      cyc++;
    end
    n_checks++;
    if (done_cyc !== 97) begin n_fail++; $display("FAIL abort_done_cycle: got %0d expected 97", done_cyc); end
    n_checks++;
    if (son !== 0 || wr !== 0 || ovr !== 1) begin
      n_fail++; $display("FAIL abort_after: got son=%0d wr=%0d ovr=%0d expected 0/0/1", son, wr, ovr);
    end
  endtask

  task automatic test_timeout();
    clear_bank();
    bank[0] = word(1'b1, 10'd100, 10'd50, 9'd0);
    n_checks++;
    if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_pre: got %b expected 0", bus.timeout_err); end
    cf_en = 1'b0;
    run_scan(10'd55);
    cf_en = 1'b1;
    n_checks++;
    if (s_son !== 32 || s_wr !== 32) begin
      n_fail++; $display("FAIL timeout_draw_len: got son=%0d wr=%0d expected 32/32", s_son, s_wr);
    end
    n_checks++;
    if (s_done_cyc !== 131 || s_done_cnt !== 1) begin
      n_fail++; $display("FAIL timeout_done: got cyc=%0d pulses=%0d expected 131/1", s_done_cyc, s_done_cnt);
    end
    n_checks++;
    if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_flag: got %b expected 1", bus.timeout_err); end
    run_scan(10'd55);
    n_checks++;
    if (bus.timeout_err !== 1'b1 || s_son !== 20) begin
      n_fail++; $display("FAIL timeout_sticky: got tmo=%b son=%0d expected 1/20", bus.timeout_err, s_son);
    end
  endtask

  task automatic test_reset_mid_draw();
    int k;
    clear_bank();
    bank[0] = word(1'b1, 10'd100, 10'd50, 9'd0);
    pulse_line(10'd55);
    k = 0;
    while (k < 200 && !(bus.lb_wr_en && bus.sprite_on)) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (!(bus.lb_wr_en && bus.sprite_on)) begin
      n_fail++; $display("FAIL rstdraw_reach: got lb_wr_en=%b son=%b expected 1/1", bus.lb_wr_en, bus.sprite_on);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.sprite_on, bus.lb_wr_en, bus.busy, bus.timeout_err} !== 4'b0) begin
      n_fail++;
      $display("FAIL rstdraw_async: got son=%b wr=%b busy=%b tmo=%b expected 0000",
               bus.sprite_on, bus.lb_wr_en, bus.busy, bus.timeout_err);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_boundary();
    test_right_edge();
    test_all_disabled();
    test_multi_hit();
    test_abort();
    test_timeout();
    test_reset_mid_draw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
